// File: rtl/timer_counter.sv
// ---------------------------------------------------------------------------
// timer_counter
//
// Memory-mapped down-counting timer with one-shot and auto-reload modes and a
// maskable interrupt request.
//
// Register map (word offset on Addr):
//   0 CTRL   : bit0 En, bits[2:1] Mode (1 = auto-reload, else one-shot),
//              bit3 IM (interrupt mask); upper bits read 0
//   1 PRESET : 32-bit reload value
//   2 COUNT  : current count (read-only)
//   3 unused : reads 0, writes ignored
//
// Ports:
//   clk   - sole clock, rising edge
//   reset - asynchronous active-low reset
//   Addr  - register word offset
//   We    - write strobe for this device
//   Din   - write data
//   Dout  - combinational read data for Addr
//   IRQ   - interrupt request (pending AND IM)
// ---------------------------------------------------------------------------
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        We,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic [31:0] count_next;
    logic        irq_pend;

    logic        irq_set;      // terminal count reached this cycle
    logic        irq_clr_fsm;  // auto-reload leaving INT: end the pulse
    logic        en_clr;       // one-shot leaving INT: drop En

    logic        en;
    logic        auto_reload;
    logic        wr_ctrl;
    logic        wr_preset;

    assign en          = ctrl[0];
    assign auto_reload = (ctrl[2:1] == 2'b01);
    assign wr_ctrl     = We && (Addr == 2'd0);
    assign wr_preset   = We && (Addr == 2'd1);

    // Next-state and datapath control
    always_comb begin
        state_next  = state;
        count_next  = count;
        irq_set     = 1'b0;
        irq_clr_fsm = 1'b0;
        en_clr      = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                count_next = preset;
                state_next = CNT;
            end
            CNT: begin
                if (!en) begin
                    state_next = IDLE;
                end else if (count > 32'd1) begin
                    count_next = count - 32'd1;
                end else begin
                    // Covers COUNT of 1 and 0, so the count never wraps.
                    count_next = 32'd0;
                    irq_set    = 1'b1;
                    state_next = INT;
                end
            end
            INT: begin
                if (auto_reload) begin
                    irq_clr_fsm = 1'b1;
                    state_next  = LOAD;
                end else begin
                    en_clr     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 32'd0;
        end else begin
            count <= count_next;
        end
    end

    // CTRL: a CPU write takes priority over the one-shot En clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl <= 4'd0;
        end else if (wr_ctrl) begin
            ctrl <= Din[3:0];
        end else if (en_clr) begin
            ctrl[0] <= 1'b0;
        end
    end

    // PRESET: only sampled by LOAD, so writes mid-count do not disturb COUNT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preset <= 32'd0;
        end else if (wr_preset) begin
            preset <= Din;
        end
    end

    // Interrupt pending: any CTRL/PRESET write acknowledges, and wins over a
    // terminal count landing on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_pend <= 1'b0;
        end else if (wr_ctrl || wr_preset) begin
            irq_pend <= 1'b0;
        end else if (irq_set) begin
            irq_pend <= 1'b1;
        end else if (irq_clr_fsm) begin
            irq_pend <= 1'b0;
        end
    end

    // Read mux
    always_comb begin
        Dout = 32'd0;
        case (Addr)
            2'd0:    Dout = {28'd0, ctrl};
            2'd1:    Dout = preset;
            2'd2:    Dout = count;
            default: Dout = 32'd0;
        endcase
    end

    // Registers only, so no combinational path from the bus inputs.
    assign IRQ = irq_pend & ctrl[3];

endmodule

// File: tb/tb_timer_counter.sv
// ---------------------------------------------------------------------------
// tb_timer_counter
//
// Directed bench for timer_counter. Inputs change 1 time unit after a rising
// edge and outputs are sampled in the same quiet window. "E<n>" in the step
// comments numbers the edges of each scenario, E0 being the edge that
// latches the CTRL write that starts it.
// ---------------------------------------------------------------------------
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [1:0]  Addr;
    logic        We;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int vectors;
    int miscompares;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .We    (We),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write lands on the next rising edge; returns 1 unit after it.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        Din  = d;
        We   = 1'b1;
        step();
        We   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        Addr = a;
        #1;
        chk(tag, Dout, exp);
    endtask

    task automatic chk_irq(input logic exp, input string tag);
        chk(tag, {31'd0, IRQ}, {31'd0, exp});
    endtask

    // Auto-reload, PRESET=3: expected COUNT and IRQ after edges E2..E12
    logic [31:0] b_cnt [11];
    logic        b_irq [11];
    // One-shot, PRESET=5: expected COUNT and IRQ after edges E2..E7
    logic [31:0] a_cnt [6];
    logic        a_irq [6];

    initial begin
        b_cnt = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd3};
        b_irq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        a_cnt = '{32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
        a_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        vectors     = 0;
        miscompares = 0;
        reset = 1'b0;
        Addr  = 2'd0;
        We    = 1'b0;
        Din   = 32'd0;

        // ---------------- Reset state ----------------
        #2;
        rd(2'd0, 32'd0, "rst_ctrl");
        rd(2'd1, 32'd0, "rst_preset");
        rd(2'd2, 32'd0, "rst_count");
        chk_irq(1'b0, "rst_irq");
        @(negedge clk);
        reset = 1'b1;
        step();

        // ---------------- One-shot with IM ----------------
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);                        // E0
        rd(2'd0, 32'h9, "a_ctrl_e0");
        step();                                 // E1: IDLE -> LOAD
        rd(2'd2, 32'd0, "a_count_e1");
        for (int i = 0; i < 6; i++) begin       // E2..E7
            step();
            rd(2'd2, a_cnt[i], $sformatf("a_count_e%0d", i + 2));
            chk_irq(a_irq[i], $sformatf("a_irq_e%0d", i + 2));
        end
        step();                                 // E8: INT -> IDLE, En cleared
        rd(2'd0, 32'h8, "a_ctrl_e8");
        chk_irq(1'b1, "a_irq_e8");
        step();                                 // E9: still pending
        chk_irq(1'b1, "a_irq_e9");
        wr(2'd0, 32'h9);                        // acknowledge, restarts
        chk_irq(1'b0, "a_irq_ack");
        wr(2'd0, 32'h0);                        // IDLE->LOAD on this edge
        step();                                 // LOAD: COUNT=5
        step();                                 // CNT with En=0 -> IDLE
        step();
        rd(2'd2, 32'd5, "a_count_paused");

        // ---------------- Auto-reload with IM ----------------
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);                        // E0
        step();                                 // E1
        rd(2'd2, 32'd5, "b_count_e1_held");
        for (int i = 0; i < 11; i++) begin      // E2..E12
            step();
            rd(2'd2, b_cnt[i], $sformatf("b_count_e%0d", i + 2));
            chk_irq(b_irq[i], $sformatf("b_irq_e%0d", i + 2));
        end
        wr(2'd0, 32'h0);                        // E13: last decrement to 2
        rd(2'd2, 32'd2, "b_count_e13");
        step();                                 // E14: pause in IDLE
        rd(2'd2, 32'd2, "b_count_e14");

        // ---------------- IM=0 never raises IRQ ----------------
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);                        // E0
        for (int i = 1; i <= 4; i++) begin      // E1..E4
            step();
            chk_irq(1'b0, $sformatf("c_irq_e%0d", i));
        end
        rd(2'd2, 32'd0, "c_count_e4");
        step();                                 // E5: one-shot clears En
        rd(2'd0, 32'h0, "c_ctrl_e5");
        chk_irq(1'b0, "c_irq_e5");
        wr(2'd0, 32'h9);                        // unmask; write clears pending
        chk_irq(1'b0, "c_irq_unmask");
        wr(2'd0, 32'h0);
        step();
        step();

        // ---------------- PRESET write mid-count ----------------
        wr(2'd1, 32'd12);
        wr(2'd0, 32'h3);                        // E0: En, auto-reload, IM=0
        step();                                 // E1
        step();                                 // E2
        rd(2'd2, 32'd12, "d_count_e2");
        step();                                 // E3
        step();                                 // E4
        rd(2'd2, 32'd10, "d_count_e4");
        wr(2'd1, 32'd100);                      // E5
        rd(2'd2, 32'd9, "d_count_e5");
        step();                                 // E6
        rd(2'd2, 32'd8, "d_count_e6");
        repeat (8) step();                      // E14: terminal count
        rd(2'd2, 32'd0, "d_count_e14");
        step();                                 // E15: LOAD
        rd(2'd2, 32'd0, "d_count_e15");
        step();                                 // E16: reloaded with new PRESET
        rd(2'd2, 32'd100, "d_count_e16");
        step();                                 // E17
        rd(2'd2, 32'd99, "d_count_e17");

        // ---------------- Asynchronous reset mid-count ----------------
        #2;
        reset = 1'b0;
        rd(2'd2, 32'd0, "e_count_async");
        chk_irq(1'b0, "e_irq_async");
        rd(2'd0, 32'd0, "e_ctrl_async");
        rd(2'd1, 32'd0, "e_preset_async");
        @(negedge clk);
        reset = 1'b1;
        repeat (3) step();
        rd(2'd2, 32'd0, "e_count_idle");
        rd(2'd0, 32'd0, "e_ctrl_idle");

        // ---------------- Writes to COUNT / unused are ignored ----------------
        wr(2'd1, 32'd7);
        wr(2'd0, 32'h1);                        // E0
        step();                                 // E1
        step();                                 // E2
        rd(2'd2, 32'd7, "f_count_e2");
        step();                                 // E3
        wr(2'd2, 32'hFFFF_FFFF);                // E4
        rd(2'd2, 32'd5, "f_count_wr2");
        rd(2'd3, 32'd0, "f_unused_rd");
        wr(2'd3, 32'hFFFF_FFFF);                // E5
        rd(2'd2, 32'd4, "f_count_wr3");
        rd(2'd3, 32'd0, "f_unused_rd2");
        rd(2'd1, 32'd7, "f_preset");
        wr(2'd0, 32'h0);                        // E6: decrement to 3
        step();                                 // E7: paused
        rd(2'd2, 32'd3, "f_count_paused");

        // ------- PRESET=0 latency, Mode=2 one-shot, CPU write wins in INT -------
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);                        // E0
        step();                                 // E1
        chk_irq(1'b0, "g_irq_e1");
        step();                                 // E2
        rd(2'd2, 32'd0, "g_count_e2");
        chk_irq(1'b0, "g_irq_e2");
        step();                                 // E3: INT
        chk_irq(1'b1, "g_irq_e3");
        wr(2'd0, 32'hD);                        // E4: same edge as En clear
        rd(2'd0, 32'hD, "g_ctrl_e4");
        chk_irq(1'b0, "g_irq_e4");
        step();                                 // E5: IDLE -> LOAD
        step();                                 // E6: LOAD
        chk_irq(1'b0, "g_irq_e6");
        step();                                 // E7: INT again
        chk_irq(1'b1, "g_irq_e7");
        step();                                 // E8: Mode=2 acts as one-shot
        rd(2'd0, 32'hC, "g_ctrl_e8");
        chk_irq(1'b1, "g_irq_e8");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net against a stalled run
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 Parameters: none; register map and widths fixed by this document.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; low forces reset state immediately, regardless of clk.
REQ-004 Addr  input  2  word offset [3:2] within the device window: 0=CTRL, 1=PRESET, 2=COUNT, 3=unused.
REQ-005 We  input  1  write strobe, already qualified by the bridge for this device's window.
REQ-006 Din  input  32  write data.
REQ-007 Dout  output  32  read data for Addr, combinational.
REQ-008 IRQ  output  1  interrupt request to the bridge's hardware-interrupt input.

Function
REQ-009 CTRL fields: bit0 En (enable), bits[2:1] Mode, bit3 IM (interrupt mask); bits[31:4] SHALL read 0 and ignore writes.
REQ-010 Mode decoding: 0 = one-shot, 1 = auto-reload; 2 and 3 SHALL behave as one-shot.
REQ-011 Write with Addr=0 loads CTRL[3:0]; Addr=1 loads PRESET[31:0]; Addr=2 or 3 writes are ignored.
REQ-012 Dout: Addr=0 gives {28'b0, CTRL[3:0]}; Addr=1 gives PRESET; Addr=2 gives COUNT; Addr=3 gives 0.
REQ-013 FSM states: IDLE, LOAD, CNT, INT; the state is internal and not a port.
REQ-014 IDLE: if En=1, go to LOAD next edge; otherwise stay; COUNT is held.
REQ-015 LOAD: COUNT<=PRESET; go to CNT.
REQ-016 CNT with En=0: go to IDLE; COUNT is held (pause).
REQ-017 CNT with En=1 and COUNT>1: COUNT<=COUNT-1.
REQ-018 CNT with En=1 and COUNT<=1: COUNT<=0; set irq_pend; go to INT.
REQ-019 INT, one-shot: clear En; go to IDLE; irq_pend stays set.
REQ-020 INT, auto-reload: go to LOAD; irq_pend clears at the exit edge (one-cycle pulse).
REQ-021 Terminal-count latency: En written at edge E0 with PRESET=N>=1 gives COUNT=N at E2, COUNT=0 and INT at E(N+2); PRESET=0 reaches INT at E3.
REQ-022 IRQ = irq_pend AND IM, combinational from registers; no glitch path from Din or Addr.
REQ-023 Any write to CTRL or PRESET clears irq_pend on that edge.
REQ-024 Same-edge CTRL write and FSM En-clear in INT: the CPU write wins (CTRL takes Din); the state still goes to IDLE.
REQ-025 A PRESET write during CNT does not alter COUNT; the new value applies at the next LOAD.
REQ-026 A CTRL write with En=0 during CNT pauses at the next edge; a later En=1 resumes via LOAD (COUNT reloaded, not resumed).
REQ-027 COUNT never wraps below 0; the decrement is 32-bit unsigned.

Reset
REQ-028 reset low: CTRL=0, PRESET=0, COUNT=0, irq_pend=0, state=IDLE, IRQ=0, Dout reflects zeroed registers.
REQ-029 reset asserted mid-count: counting aborts immediately; after release the block stays IDLE until En is written.
REQ-030 Reset release is synchronous to clk upstream; no internal synchronizer is required.

Verification
REQ-031 Bench SHALL cover: PRESET=5, CTRL=0x9 (En, one-shot, IM) -> COUNT 5,4,3,2,1,0; IRQ=1 from E7 onward; CTRL reads 0x8; IRQ falls after a write of CTRL=0x9.
REQ-032 Bench SHALL cover: PRESET=3, CTRL=0xB (auto-reload, IM) -> IRQ pulses exactly one cycle every 5 cycles; COUNT sequence 3,2,1,0,0(LOAD),3...
REQ-033 Bench SHALL cover: CTRL=0x1 (IM=0), PRESET=2 -> IRQ stays 0 throughout; a later CTRL=0x9 write clears irq_pend and IRQ remains 0.
REQ-034 Bench SHALL cover: during CNT at COUNT=10, write PRESET=100 -> count continues 9,8,...; next reload uses 100.
REQ-035 Bench SHALL cover: reset pulled low between edges mid-count -> COUNT=0, IRQ=0 with no clock edge; Dout(Addr=0)=0.
REQ-036 Bench SHALL cover: write Addr=2 with 0xFFFF_FFFF -> COUNT unchanged; Addr=3 reads 0.
